// File: rtl/ctrl_fsm_if.sv
// ctrl_fsm_if: instruction fetch handshake between an instruction source
// (master) and the control FSM (slave). The source presents instr with
// instrValid; the controller raises instrReq while it is waiting in FETCH.
interface ctrl_fsm_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] instr;
  logic             instrValid;
  logic             instrReq;

  modport master (output instr, output instrValid, input instrReq);
  modport slave  (input instr, input instrValid, output instrReq);
endinterface

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: four-phase (FETCH -> DECODE -> EXEC -> WB) instruction controller
// driving register-file / ALU / PC control signals. All outputs are registered
// and represent the phase the FSM is currently in.
// Optional feature: define CTRL_JAL_EN to decode JAL (op 0100, ext 1000);
// without it that encoding is illegal and jalEN stays 0.
module ctrl_fsm #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  ctrl_fsm_if.slave          fetch,
  input  logic [7:0]         PSR,
  output logic               regWrite,
  output logic               shiftOrALU,
  output logic               alusrca,
  output logic               alusrcb,
  output logic               shiftType,
  output logic [REGBITS-1:0] aluControl,
  output logic [REGBITS-1:0] regAddress1,
  output logic [REGBITS-1:0] regAddress2,
  output logic [WIDTH-1:0]   immediate,
  output logic               jumpEN,
  output logic               jalEN,
  output logic               pcEn,
  output logic               illegal
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_ITYPE   = 3'd1,
    CLS_SHIFT   = 3'd2,
    CLS_JCOND   = 3'd3,
    CLS_JAL     = 3'd4,
    CLS_ILLEGAL = 3'd5
  } instrClass_t;

  state_t             state_r;
  logic [WIDTH-1:0]   ir_r;
  logic               instrReq_r;

  logic [3:0]         op_s;
  logic [3:0]         ext_s;
  logic [3:0]         rdest_s;
  logic [3:0]         rsrc_s;
  instrClass_t        cls_s;
  logic               taken_s;
  logic               writes_s;
  logic               decShiftOrALU_s;
  logic               decAlusrca_s;
  logic               decAlusrcb_s;
  logic               decShiftType_s;
  logic [REGBITS-1:0] decAluControl_s;
  logic [WIDTH-1:0]   decImmediate_s;
  logic               unusedPsr_s;

  assign fetch.instrReq = instrReq_r;

  // PSR[7:5] carry no flag this controller consumes.
  assign unusedPsr_s = ^PSR[7:5];

  assign op_s    = ir_r[15:12];
  assign rdest_s = ir_r[11:8];
  assign ext_s   = ir_r[7:4];
  assign rsrc_s  = ir_r[3:0];

  // Classify the latched instruction word.
  always_comb begin
    cls_s = CLS_ILLEGAL;
    case (op_s)
      4'b0000: cls_s = CLS_RTYPE;
      4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110, 4'b0111,
      4'b1001, 4'b1011, 4'b1101, 4'b1110, 4'b1111: cls_s = CLS_ITYPE;
      4'b1000: cls_s = CLS_SHIFT;
      4'b0100: begin
        if (ext_s == 4'b1100) begin
          cls_s = CLS_JCOND;
        end
`ifdef CTRL_JAL_EN
        else if (ext_s == 4'b1000) begin
          cls_s = CLS_JAL;
        end
`endif
        else begin
          cls_s = CLS_ILLEGAL;
        end
      end
      default: cls_s = CLS_ILLEGAL;
    endcase
  end

  // Jcond condition, selected by Rdest, from the PSR presented during EXEC.
  always_comb begin
    taken_s = 1'b0;
    case (rdest_s)
      4'b1110: taken_s = 1'b1;
      4'b0000: taken_s = PSR[1];
      4'b0001: taken_s = ~PSR[1];
      4'b0010: taken_s = PSR[0];
      4'b0011: taken_s = PSR[2];
      4'b0100: taken_s = PSR[3];
      4'b0101: taken_s = PSR[4];
      default: taken_s = 1'b0;
    endcase
  end

  // Datapath controls implied by the instruction class. Jcond and illegal
  // instructions leave the datapath idle; JAL routes PC (alusrca=0) to Rdest.
  always_comb begin
    writes_s        = 1'b0;
    decShiftOrALU_s = 1'b0;
    decAlusrca_s    = 1'b0;
    decAlusrcb_s    = 1'b0;
    decShiftType_s  = 1'b0;
    decAluControl_s = {REGBITS{1'b0}};
    decImmediate_s  = {WIDTH{1'b0}};
    case (cls_s)
      CLS_RTYPE: begin
        writes_s        = 1'b1;
        decShiftOrALU_s = 1'b1;
        decAlusrca_s    = 1'b1;
        decAluControl_s = REGBITS'(ext_s);
      end
      CLS_ITYPE: begin
        writes_s        = 1'b1;
        decShiftOrALU_s = 1'b1;
        decAlusrca_s    = 1'b1;
        decAlusrcb_s    = 1'b1;
        decAluControl_s = REGBITS'(op_s);
        decImmediate_s  = {{(WIDTH-8){ir_r[7]}}, ir_r[7:0]};
      end
      CLS_SHIFT: begin
        writes_s        = 1'b1;
        decAlusrca_s    = 1'b1;
        decAlusrcb_s    = ext_s[2];
        decShiftType_s  = ext_s[0];
        decImmediate_s  = {{(WIDTH-4){1'b0}}, rsrc_s};
      end
      CLS_JAL: begin
        writes_s        = 1'b1;
        decShiftOrALU_s = 1'b1;
      end
      default: begin
        writes_s        = 1'b0;
      end
    endcase
  end

  // Phase sequencer; each branch registers the outputs of the phase it enters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= FETCH;
      ir_r        <= {WIDTH{1'b0}};
      instrReq_r  <= 1'b1;
      regWrite    <= 1'b0;
      shiftOrALU  <= 1'b0;
      alusrca     <= 1'b0;
      alusrcb     <= 1'b0;
      shiftType   <= 1'b0;
      aluControl  <= {REGBITS{1'b0}};
      regAddress1 <= {REGBITS{1'b0}};
      regAddress2 <= {REGBITS{1'b0}};
      immediate   <= {WIDTH{1'b0}};
      jumpEN      <= 1'b0;
      jalEN       <= 1'b0;
      pcEn        <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      regWrite <= 1'b0;
      pcEn     <= 1'b0;
      jumpEN   <= 1'b0;
      jalEN    <= 1'b0;
      case (state_r)
        FETCH: begin
          if (fetch.instrValid) begin
            state_r     <= DECODE;
            ir_r        <= fetch.instr;
            instrReq_r  <= 1'b0;
            regAddress1 <= REGBITS'(fetch.instr[11:8]);
            regAddress2 <= REGBITS'(fetch.instr[3:0]);
          end else begin
            state_r     <= FETCH;
            instrReq_r  <= 1'b1;
          end
        end
        DECODE: begin
          state_r    <= EXEC;
          shiftOrALU <= decShiftOrALU_s;
          alusrca    <= decAlusrca_s;
          alusrcb    <= decAlusrcb_s;
          shiftType  <= decShiftType_s;
          aluControl <= decAluControl_s;
          immediate  <= decImmediate_s;
        end
        EXEC: begin
          state_r  <= WB;
          regWrite <= writes_s;
          pcEn     <= 1'b1;
          jumpEN   <= ((cls_s == CLS_JCOND) && taken_s) || (cls_s == CLS_JAL);
`ifdef CTRL_JAL_EN
          jalEN    <= (cls_s == CLS_JAL);
`else
          jalEN    <= 1'b0;
`endif
          if (cls_s == CLS_ILLEGAL) begin
            illegal <= 1'b1;
          end else begin
            illegal <= illegal;
          end
        end
        WB: begin
          state_r     <= FETCH;
          instrReq_r  <= 1'b1;
          shiftOrALU  <= 1'b0;
          alusrca     <= 1'b0;
          alusrcb     <= 1'b0;
          shiftType   <= 1'b0;
          aluControl  <= {REGBITS{1'b0}};
          immediate   <= {WIDTH{1'b0}};
          regAddress1 <= {REGBITS{1'b0}};
          regAddress2 <= {REGBITS{1'b0}};
        end
        default: begin
          state_r     <= FETCH;
          instrReq_r  <= 1'b1;
          shiftOrALU  <= 1'b0;
          alusrca     <= 1'b0;
          alusrcb     <= 1'b0;
          shiftType   <= 1'b0;
          aluControl  <= {REGBITS{1'b0}};
          immediate   <= {WIDTH{1'b0}};
          regAddress1 <= {REGBITS{1'b0}};
          regAddress2 <= {REGBITS{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: table-driven vectors, hand-written reset sequences and
// randomized instructions checked against a behavioural model of the
// controller. Honours CTRL_JAL_EN the same way the design does.
module tb_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  PSR;
  logic        regWrite, shiftOrALU, alusrca, alusrcb, shiftType;
  logic [3:0]  aluControl, regAddress1, regAddress2;
  logic [15:0] immediate;
  logic        jumpEN, jalEN, pcEn, illegal;

  ctrl_fsm_if #(.WIDTH(16)) ifc ();

  ctrl_fsm #(.WIDTH(16), .REGBITS(4)) dut (
    .clk(clk), .reset(reset), .fetch(ifc.slave), .PSR(PSR),
    .regWrite(regWrite), .shiftOrALU(shiftOrALU), .alusrca(alusrca),
    .alusrcb(alusrcb), .shiftType(shiftType), .aluControl(aluControl),
    .regAddress1(regAddress1), .regAddress2(regAddress2),
    .immediate(immediate), .jumpEN(jumpEN), .jalEN(jalEN), .pcEn(pcEn),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        instrReq, regWrite, shiftOrALU, alusrca, alusrcb, shiftType;
    logic [3:0]  aluControl, ra1, ra2;
    logic [15:0] immediate;
    logic        jumpEN, jalEN, pcEn, illegal;
  } outs_t;

  typedef struct {
    logic [15:0] ins;
    logic [7:0]  psr;
    logic        expWrite, expJump, expJal, expPc, expSrcA, expSrcB;
    logic [3:0]  expAlu;
    logic [15:0] expImm;
    logic        expIll;
  } vec_t;

  int   nVec = 0;
  int   nMis = 0;
  logic modelIll = 1'b0;

  function automatic outs_t sample();
    outs_t s;
    s.instrReq   = ifc.instrReq;   s.regWrite  = regWrite;
    s.shiftOrALU = shiftOrALU;     s.alusrca   = alusrca;
    s.alusrcb    = alusrcb;        s.shiftType = shiftType;
    s.aluControl = aluControl;     s.ra1       = regAddress1;
    s.ra2        = regAddress2;    s.immediate = immediate;
    s.jumpEN     = jumpEN;         s.jalEN     = jalEN;
    s.pcEn       = pcEn;           s.illegal   = illegal;
    return s;
  endfunction

  // Expected outputs cyc cycles after the instruction is offered in FETCH
  // (0 = still in FETCH, 3 = write-back); psr is the value seen during EXEC.
  function automatic outs_t model(input logic [15:0] ins, input int cyc,
                                  input logic [7:0] psr, input logic sticky);
    outs_t       o;
    logic [3:0]  op, rd, ex, rs;
    logic [15:0] iMask;
    int          flagOf [0:5];
    logic        isR, isI, isSh, isJc, isJal, isIll, taken;
    int          simm;
    o = '0;
    op = ins[15:12]; rd = ins[11:8]; ex = ins[7:4]; rs = ins[3:0];
    iMask = 16'b1110_1010_1110_1110;
    flagOf = '{1, 1, 0, 2, 3, 4};
    isR = (op == 4'h0); isI = iMask[op]; isSh = (op == 4'h8);
    isJc = (op == 4'h4) && (ex == 4'hC);
    isJal = 1'b0;
`ifdef CTRL_JAL_EN
    isJal = (op == 4'h4) && (ex == 4'h8);
`endif
    isIll = !(isR || isI || isSh || isJc || isJal);
    taken = 1'b0;
    if (rd == 4'hE) taken = 1'b1;
    else if (rd <= 4'h5) begin
      taken = psr[flagOf[rd]];
      if (rd == 4'h1) taken = !taken;
    end
    simm = int'(ins[7:0]);
    if (simm > 127) simm = simm - 256;
    o.illegal = sticky;
    if (cyc == 0) o.instrReq = 1'b1;
    if (cyc >= 1) begin o.ra1 = rd; o.ra2 = rs; end
    if (cyc >= 2) begin
      if (isR) begin o.aluControl = ex; o.shiftOrALU = 1'b1; o.alusrca = 1'b1; end
      if (isI) begin
        o.aluControl = op; o.shiftOrALU = 1'b1; o.alusrca = 1'b1;
        o.alusrcb = 1'b1; o.immediate = 16'(simm);
      end
      if (isSh) begin
        o.alusrca = 1'b1; o.alusrcb = ex[2]; o.shiftType = ex[0];
        o.immediate = 16'(rs);
      end
      if (isJal) o.shiftOrALU = 1'b1;
    end
    if (cyc == 3) begin
      o.pcEn     = 1'b1;
      o.regWrite = isR || isI || isSh || isJal;
      o.jumpEN   = (isJc && taken) || isJal;
      o.jalEN    = isJal;
      o.illegal  = sticky || isIll;
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic cmpOuts(input string tag, input outs_t a, input outs_t e);
    chk({tag, ".instrReq"},   16'(a.instrReq),   16'(e.instrReq));
    chk({tag, ".regWrite"},   16'(a.regWrite),   16'(e.regWrite));
    chk({tag, ".shiftOrALU"}, 16'(a.shiftOrALU), 16'(e.shiftOrALU));
    chk({tag, ".alusrca"},    16'(a.alusrca),    16'(e.alusrca));
    chk({tag, ".alusrcb"},    16'(a.alusrcb),    16'(e.alusrcb));
    chk({tag, ".shiftType"},  16'(a.shiftType),  16'(e.shiftType));
    chk({tag, ".aluControl"}, 16'(a.aluControl), 16'(e.aluControl));
    chk({tag, ".regAddress1"},16'(a.ra1),        16'(e.ra1));
    chk({tag, ".regAddress2"},16'(a.ra2),        16'(e.ra2));
    chk({tag, ".immediate"},  a.immediate,       e.immediate);
    chk({tag, ".jumpEN"},     16'(a.jumpEN),     16'(e.jumpEN));
    chk({tag, ".jalEN"},      16'(a.jalEN),      16'(e.jalEN));
    chk({tag, ".pcEn"},       16'(a.pcEn),       16'(e.pcEn));
    chk({tag, ".illegal"},    16'(a.illegal),    16'(e.illegal));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Start at a FETCH negedge; run one instruction through all four phases,
  // checking every phase, and return the write-back outputs.
  task automatic runInstr(input logic [15:0] ins, input logic [7:0] psrExec,
                          output outs_t wbOut);
    outs_t e;
    string t;
    t = $sformatf("%04h", ins);
    cmpOuts({t, ".fetch"}, sample(), model(ins, 0, 8'h00, modelIll));
    ifc.instr = ins; ifc.instrValid = 1'b1; PSR = 8'($urandom);
    tick();
    cmpOuts({t, ".decode"}, sample(), model(ins, 1, 8'h00, modelIll));
    ifc.instr = 16'($urandom); ifc.instrValid = 1'($urandom_range(0, 1));
    PSR = 8'($urandom);
    tick();
    cmpOuts({t, ".exec"}, sample(), model(ins, 2, 8'h00, modelIll));
    PSR = psrExec; ifc.instrValid = 1'($urandom_range(0, 1));
    tick();
    e = model(ins, 3, psrExec, modelIll);
    wbOut = sample();
    cmpOuts({t, ".wb"}, wbOut, e);
    modelIll = e.illegal;
    PSR = 8'($urandom); ifc.instrValid = 1'($urandom_range(0, 1));
    tick();
    ifc.instrValid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [13];
    outs_t       wb;
    outs_t       unusedWb;
    logic [15:0] rIns;
    int          stalls;

    tbl[0]  = '{16'h0110, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h1, 16'h0000, 1'b0};
    tbl[1]  = '{16'h52FB, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 16'hFFFB, 1'b0};
    tbl[2]  = '{16'h40C3, 8'h02, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0};
    tbl[3]  = '{16'h40C3, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0};
    tbl[4]  = '{16'h8A53, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 16'h0003, 1'b0};
    tbl[5]  = '{16'h8123, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 16'h0003, 1'b0};
    tbl[6]  = '{16'h3712, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 16'h0012, 1'b0};
    tbl[7]  = '{16'h4EC0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0};
    tbl[8]  = '{16'h4FC0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0};
    tbl[9]  = '{16'h41C0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0};
    tbl[10] = '{16'h45C0, 8'h10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0};
`ifdef CTRL_JAL_EN
    tbl[11] = '{16'h4A85, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0};
`else
    tbl[11] = '{16'h4A85, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1};
`endif
    tbl[12] = '{16'hA123, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1};

    reset = 1'b0; PSR = 8'h00; ifc.instr = 16'h0000; ifc.instrValid = 1'b0;

    // Reset held low for two edges.
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b1; modelIll = 1'b0;
    cmpOuts("reset", sample(), model(16'h0000, 0, 8'h00, 1'b0));

    // Idle FETCH with no valid instruction stays put.
    for (int i = 0; i < 2; i++) begin
      tick();
      cmpOuts("idle", sample(), model(16'h0000, 0, 8'h00, modelIll));
    end

    // Table-driven vectors, write-back snapshot against hand expectations.
    for (int i = 0; i < 13; i++) begin
      string t;
      t = $sformatf("tbl%0d", i);
      runInstr(tbl[i].ins, tbl[i].psr, wb);
      chk({t, ".regWrite"},   16'(wb.regWrite),   16'(tbl[i].expWrite));
      chk({t, ".jumpEN"},     16'(wb.jumpEN),     16'(tbl[i].expJump));
      chk({t, ".jalEN"},      16'(wb.jalEN),      16'(tbl[i].expJal));
      chk({t, ".pcEn"},       16'(wb.pcEn),       16'(tbl[i].expPc));
      chk({t, ".alusrca"},    16'(wb.alusrca),    16'(tbl[i].expSrcA));
      chk({t, ".alusrcb"},    16'(wb.alusrcb),    16'(tbl[i].expSrcB));
      chk({t, ".aluControl"}, 16'(wb.aluControl), 16'(tbl[i].expAlu));
      chk({t, ".immediate"},  wb.immediate,       tbl[i].expImm);
      chk({t, ".illegal"},    16'(wb.illegal),    16'(tbl[i].expIll));
      chk({t, ".regAddress1"},16'(wb.ra1),        16'(tbl[i].ins[11:8]));
      chk({t, ".regAddress2"},16'(wb.ra2),        16'(tbl[i].ins[3:0]));
    end

    // Reset wins over instrValid in the same cycle; illegal is cleared.
    reset = 1'b0; ifc.instr = 16'h0110; ifc.instrValid = 1'b1;
    tick();
    reset = 1'b1; ifc.instrValid = 1'b0; modelIll = 1'b0;
    cmpOuts("rstprio", sample(), model(16'h0110, 0, 8'h00, 1'b0));
    tick();
    cmpOuts("rstprio+1", sample(), model(16'h0110, 0, 8'h00, 1'b0));

    // Reset during DECODE, then during EXEC, aborts the instruction.
    for (int ab = 1; ab <= 2; ab++) begin
      string t;
      t = $sformatf("abort%0d", ab);
      ifc.instr = 16'h0110; ifc.instrValid = 1'b1;
      tick();
      ifc.instrValid = 1'b0;
      if (ab == 2) tick();
      reset = 1'b0;
      tick();
      reset = 1'b1; modelIll = 1'b0;
      cmpOuts(t, sample(), model(16'h0110, 0, 8'h00, 1'b0));
      tick();
      cmpOuts({t, "+1"}, sample(), model(16'h0110, 0, 8'h00, 1'b0));
      tick();
      cmpOuts({t, "+2"}, sample(), model(16'h0110, 0, 8'h00, 1'b0));
    end

    // Randomized instructions with random FETCH stalls.
    for (int k = 0; k < 250; k++) begin
      rIns = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        rIns[15:12] = 4'h4;
        rIns[7:4]   = ($urandom_range(0, 1) == 1) ? 4'hC : 4'h8;
      end
      stalls = $urandom_range(0, 2);
      for (int s = 0; s < stalls; s++) begin
        cmpOuts("stall", sample(), model(rIns, 0, 8'h00, modelIll));
        ifc.instr = 16'($urandom); ifc.instrValid = 1'b0; PSR = 8'($urandom);
        tick();
      end
      runInstr(rIns, 8'($urandom), unusedWb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
